// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// The default widths and the multi-hot test live here so that every user agrees on them.
package encoder_pkg;

   localparam int DEFAULT_IN_W  = 4;
   localparam int DEFAULT_OUT_W = $clog2(DEFAULT_IN_W);

   // A request vector counts as multi-hot once this many bits are set.
   localparam int MULTI_MIN = 2;

   function automatic logic is_multi(input int unsigned pop_count);
      return (pop_count >= MULTI_MIN);
   endfunction

endpackage

// File: rtl/encoder_prio.sv
// Combinational core: index of the most-significant set bit, plus any/multi flags.
// This block holds no state; the enclosing encoder registers every result.
module encoder_prio
   import encoder_pkg::*;
#(
   parameter int IN_W  = DEFAULT_IN_W,
   parameter int OUT_W = $clog2(IN_W)
) (
   input  logic [IN_W-1:0]  Y,
   output logic [OUT_W-1:0] idx,
   output logic             any,
   output logic             multi
);

   int unsigned pop;

   // Scanning upward lets the last set bit seen, which is the MSB, win the index.
   always_comb begin
      idx = '0;
      any = 1'b0;
      pop = 0;
      for (int i = 0; i < IN_W; i++) begin
         if (Y[i]) begin
            idx = OUT_W'(i);
            any = 1'b1;
            pop = pop + 1;
         end
      end
      multi = is_multi(pop);
   end

endmodule

// File: rtl/encoder.sv
// Registered priority encoder: the result of Y is captured on enabled edges,
// so A/valid/multi always come straight from flip-flops with one cycle of latency.
module encoder
   import encoder_pkg::*;
#(
   parameter int IN_W  = DEFAULT_IN_W,
   parameter int OUT_W = $clog2(IN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IN_W-1:0]  Y,
   output logic [OUT_W-1:0] A,
   output logic             valid,
   output logic             multi
);

   logic [OUT_W-1:0] nxt_idx;
   logic             nxt_any;
   logic             nxt_multi;

   encoder_prio #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_prio (
      .Y     (Y),
      .idx   (nxt_idx),
      .any   (nxt_any),
      .multi (nxt_multi)
   );

   // Reset wins over enable; with enable low the last captured result is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         A     <= '0;
         valid <= 1'b0;
         multi <= 1'b0;
      end else if (en) begin
         A     <= nxt_idx;
         valid <= nxt_any;
         multi <= nxt_multi;
      end
   end

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: stimulus pushes expected results into a queue,
// and a monitor on the falling edge pops and compares them against the outputs.
module tb_encoder;

   typedef struct packed {
      logic [1:0] a;
      logic       v;
      logic       m;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] Y;
   logic [1:0] A;
   logic       valid;
   logic       multi;

   int checks;
   int errors;

   exp_t  exp_q[$];
   string tag_q[$];
   exp_t  model_state;

   encoder dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .Y     (Y),
      .A     (A),
      .valid (valid),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference priority model: search from the top bit down.
   function automatic exp_t ref_prio(input logic [3:0] y);
      exp_t r;
      r.a = 2'd0;
      r.v = (y != 4'd0);
      r.m = ($countones(y) >= 2);
      for (int i = 3; i >= 0; i--) begin
         if (y[i]) begin
            r.a = 2'(i);
            break;
         end
      end
      return r;
   endfunction

   // One clock of stimulus; the expected registered result is queued at the edge.
   task automatic applyStimulus(input logic r, input logic e, input logic [3:0] y,
                                input exp_t expv, input string tag);
      rst = r;
      en  = e;
      Y   = y;
      @(posedge clk);
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      model_state = expv;
      #1;
   endtask

   task automatic checkOutput(input exp_t expv, input string tag);
      checks++;
      if (A !== expv.a || valid !== expv.v || multi !== expv.m) begin
         errors++;
         $display("[TB] FAIL %s: got A=%0d valid=%0d multi=%0d, expected A=%0d valid=%0d multi=%0d",
                  tag, A, valid, multi, expv.a, expv.v, expv.m);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front(), tag_q.pop_front());
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Hand-derived truth table for Y = 0..12 as {A, valid, multi}.
   exp_t sweep_tbl [0:12];

   initial begin
      exp_t rnd_exp;
      logic [3:0] ry;
      logic       re;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      en  = 1'b1;
      Y   = 4'hF;
      model_state = '0;

      sweep_tbl[0]  = '{2'd0, 1'b0, 1'b0};
      sweep_tbl[1]  = '{2'd0, 1'b1, 1'b0};
      sweep_tbl[2]  = '{2'd1, 1'b1, 1'b0};
      sweep_tbl[3]  = '{2'd1, 1'b1, 1'b1};
      sweep_tbl[4]  = '{2'd2, 1'b1, 1'b0};
      sweep_tbl[5]  = '{2'd2, 1'b1, 1'b1};
      sweep_tbl[6]  = '{2'd2, 1'b1, 1'b1};
      sweep_tbl[7]  = '{2'd2, 1'b1, 1'b1};
      sweep_tbl[8]  = '{2'd3, 1'b1, 1'b0};
      sweep_tbl[9]  = '{2'd3, 1'b1, 1'b1};
      sweep_tbl[10] = '{2'd3, 1'b1, 1'b1};
      sweep_tbl[11] = '{2'd3, 1'b1, 1'b1};
      sweep_tbl[12] = '{2'd3, 1'b1, 1'b1};

      // Reset held two cycles with all requests active and enable high.
      applyStimulus(1'b1, 1'b1, 4'hF, '{2'd0, 1'b0, 1'b0}, "reset_c0");
      applyStimulus(1'b1, 1'b1, 4'hF, '{2'd0, 1'b0, 1'b0}, "reset_c1");

      // Sweep, each value held for ten cycles.
      for (int v = 0; v <= 12; v++) begin
         for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b1, 4'(v), sweep_tbl[v], $sformatf("sweep_y%0d", v));
         end
      end

      // Enable low holds the previous result while Y changes.
      applyStimulus(1'b0, 1'b1, 4'd4, '{2'd2, 1'b1, 1'b0}, "hold_load");
      applyStimulus(1'b0, 1'b0, 4'd8, '{2'd2, 1'b1, 1'b0}, "hold_c0");
      applyStimulus(1'b0, 1'b0, 4'd8, '{2'd2, 1'b1, 1'b0}, "hold_c1");
      applyStimulus(1'b0, 1'b0, 4'd8, '{2'd2, 1'b1, 1'b0}, "hold_c2");
      applyStimulus(1'b0, 1'b1, 4'd8, '{2'd3, 1'b1, 1'b0}, "hold_release");

      // Mid-stream reset pulse, then normal capture on the next edge.
      applyStimulus(1'b0, 1'b1, 4'd8, '{2'd3, 1'b1, 1'b0}, "midrst_pre");
      applyStimulus(1'b1, 1'b1, 4'd8, '{2'd0, 1'b0, 1'b0}, "midrst_pulse");
      applyStimulus(1'b0, 1'b1, 4'd8, '{2'd3, 1'b1, 1'b0}, "midrst_post");

      // Reset while enable is low still clears the outputs.
      applyStimulus(1'b1, 1'b0, 4'd5, '{2'd0, 1'b0, 1'b0}, "rst_over_en");
      applyStimulus(1'b0, 1'b0, 4'd5, '{2'd0, 1'b0, 1'b0}, "rst_then_hold");

      // Random Y and enable against the reference model.
      for (int n = 0; n < 250; n++) begin
         ry = 4'($urandom_range(0, 15));
         re = 1'($urandom_range(0, 1));
         rnd_exp = re ? ref_prio(ry) : model_state;
         applyStimulus(1'b0, re, ry, rnd_exp, $sformatf("random_y%0d_en%0d", ry, re));
      end

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
